registered_mux_nto1: RTL and testbench
======================================

// Module: registered_mux_nto1
//
// PURPOSE
//  Parametrised M-input, N-bit multiplexer with a single output register stage.
//  Sits at pipeline-register boundaries of the MIPS datapath, e.g. forwarding or
//  writeback select, and replaces fixed-arity combinational muxes there.
//  Supports stall (hold), flush (bubble), valid tracking and out-of-range
//  selector detection, with a saturating error counter.
//
// PARAMETERS
//  N      32  data width per input, >=1
//  M      4   number of data inputs, >=2
//  CNT_W  8   width of Error_Count
//  SEL_W  (localparam) $clog2(M); selector width
//
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous, active-high reset
//  Valid_In     in   1      inputs/selector are meaningful this cycle
//  Stall        in   1      hold all registered state
//  Flush        in   1      insert bubble; priority over Stall
//  Err_Clear    in   1      synchronous clear of Sel_Error and Error_Count
//  Selector     in   SEL_W  input index; legal range 0..M-1
//  MUX_Data     in   M*N    flattened inputs; input k = MUX_Data[k*N +: N]
//  MUX_Output   out  N      registered selected data
//  Valid_Out    out  1      MUX_Output is valid
//  Sel_Error    out  1      sticky flag: a valid out-of-range select was captured
//  Error_Count  out  CNT_W  count of valid out-of-range captures, saturating
//
// BEHAVIOUR
//  - Reset (async assert, held) sets MUX_Output=0, Valid_Out=0, Sel_Error=0,
//    Error_Count=0. Deassertion is synchronous to clk (external synchroniser).
//  - Latency is 1 cycle: inputs sampled at edge k appear on the outputs after
//    edge k. There is no combinational path from input to output.
//  - Priority at each rising edge is Flush > Stall > capture.
//    Flush:   MUX_Output<=0, Valid_Out<=0.
//    Stall:   MUX_Output and Valid_Out hold.
//    Capture: MUX_Output <= input[Selector] when Selector<M, else 0.
//             Valid_Out <= Valid_In.
//  - Data is captured regardless of Valid_In, but Valid_Out reflects Valid_In.
//  - Out-of-range event (oor) = capture cycle AND Valid_In AND Selector>=M.
//    Selector is not checked during flush or stall cycles, or when Valid_In=0.
//  - Sel_Error is set on oor and stays set until Err_Clear or reset.
//  - Error_Count increments on oor. It saturates at 2^CNT_W-1 and never wraps.
//  - Err_Clear is independent of Stall and Flush. If it coincides with oor,
//    clear wins: Sel_Error=0 and Error_Count=0.
//  - When M is a power of two, no out-of-range value exists. Sel_Error and
//    Error_Count then stay 0 and the range logic is optimised away.
//  - Reset asserted mid-stall or mid-flush forces the reset values immediately,
//    without waiting for a clock edge.
//
// TESTING
//  1. N=32,M=3: Valid_In=1, Sel=0..2, inputs A/B/C -> next cycle outputs A,B,C;
//     Valid_Out=1.
//  2. Stall=1 for 3 cycles while Sel and data change -> MUX_Output and
//     Valid_Out unchanged; resume on Stall=0.
//  3. Flush=1 with Stall=1 and Valid_In=1 -> MUX_Output=0, Valid_Out=0,
//     Error_Count unchanged.
//  4. M=3, Sel=3, Valid_In=1 -> MUX_Output=0, Valid_Out=1, Sel_Error=1,
//     Error_Count=1. Same with Valid_In=0 -> no error.
//  5. CNT_W=2, 5 oor events -> Error_Count=3; then Err_Clear together with oor
//     -> count 0, flag 0.
//  6. Assert reset between clock edges during an active stream -> all outputs
//     0 before the next edge; normal capture on the first edge after release.

Source files
------------

// File: rtl/registered_mux_nto1.sv
// M-input, N-bit multiplexer with one output register stage,
// stall/flush control and out-of-range selector tracking.
module registered_mux_nto1 #(
  parameter  int N     = 32,
  parameter  int M     = 4,
  parameter  int CNT_W = 8,
  localparam int SEL_W = $clog2(M)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Valid_In,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             Err_Clear,
  input  logic [SEL_W-1:0] Selector,
  input  logic [M*N-1:0]   MUX_Data,
  output logic [N-1:0]     MUX_Output,
  output logic             Valid_Out,
  output logic             Sel_Error,
  output logic [CNT_W-1:0] Error_Count
);

  logic [N-1:0]     w_sel_data;
  logic             w_in_range;
  logic             w_capture;
  logic             w_oor;

  logic [N-1:0]     r_out;
  logic             r_vld;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  // Decode by equality so an illegal index never forms an out-of-range slice;
  // for power-of-two M every code hits and the range check folds away.
  always_comb begin
    w_sel_data = '0;
    w_in_range = 1'b0;
    for (int k = 0; k < M; k++) begin
      if (Selector == SEL_W'(k)) begin
        w_sel_data = MUX_Data[k*N +: N];
        w_in_range = 1'b1;
      end
    end
  end

  assign w_capture = !Flush && !Stall;
  assign w_oor     = w_capture && Valid_In && !w_in_range;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= '0;
      r_vld <= 1'b0;
    end else if (Flush) begin
      r_out <= '0;
      r_vld <= 1'b0;
    end else if (!Stall) begin
      r_out <= w_sel_data;
      r_vld <= Valid_In;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end else if (Err_Clear) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end else if (w_oor) begin
      r_err <= 1'b1;
      if (r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign MUX_Output  = r_out;
  assign Valid_Out   = r_vld;
  assign Sel_Error   = r_err;
  assign Error_Count = r_cnt;

endmodule

// File: tb/tb_registered_mux_nto1.sv
// Directed bench: M=3 instance with a 2-bit error counter,
// plus an M=4 instance where no out-of-range code exists.
module tb_registered_mux_nto1;

  logic        clk = 1'b0;
  logic        reset;
  logic        vin, stall, flush, eclr;
  logic [1:0]  sel;
  logic [95:0] data;
  logic [31:0] out;
  logic        vout, serr;
  logic [1:0]  cnt;

  logic [1:0]  sel2;
  logic [31:0] data2;
  logic [7:0]  out2;
  logic        vout2, serr2;
  logic [7:0]  cnt2;

  int errs   = 0;
  int checks = 0;

  localparam logic [31:0] A = 32'h1111_AAAA;
  localparam logic [31:0] B = 32'h2222_BBBB;
  localparam logic [31:0] C = 32'h3333_CCCC;
  localparam logic [31:0] D = 32'h4444_DDDD;
  localparam logic [31:0] E = 32'h5555_EEEE;
  localparam logic [31:0] F = 32'h6666_FFFF;

  always #5 clk = ~clk;

  registered_mux_nto1 #(.N(32), .M(3), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .Valid_In(vin), .Stall(stall),
    .Flush(flush), .Err_Clear(eclr), .Selector(sel),
    .MUX_Data(data), .MUX_Output(out), .Valid_Out(vout),
    .Sel_Error(serr), .Error_Count(cnt)
  );

  registered_mux_nto1 #(.N(8), .M(4), .CNT_W(8)) dut4 (
    .clk(clk), .reset(reset), .Valid_In(vin), .Stall(stall),
    .Flush(flush), .Err_Clear(eclr), .Selector(sel2),
    .MUX_Data(data2), .MUX_Output(out2), .Valid_Out(vout2),
    .Sel_Error(serr2), .Error_Count(cnt2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag,
                         input logic [31:0] e_out,
                         input logic e_v, input logic e_err,
                         input logic [1:0] e_cnt);
    chk({tag, ".out"}, out, e_out);
    chk({tag, ".vld"}, {31'd0, vout}, {31'd0, e_v});
    chk({tag, ".err"}, {31'd0, serr}, {31'd0, e_err});
    chk({tag, ".cnt"}, {30'd0, cnt}, {30'd0, e_cnt});
  endtask

  initial begin
    reset = 1'b1; vin = 1'b0; stall = 1'b0; flush = 1'b0; eclr = 1'b0;
    sel = 2'd0; data = {C, B, A};
    sel2 = 2'd3; data2 = 32'h4433_2211;
    step();
    step();
    chk_all("rst", 32'd0, 1'b0, 1'b0, 2'd0);
    chk("rst4.out", {24'd0, out2}, 32'd0);
    reset = 1'b0;

    vin = 1'b1;
    sel = 2'd0; step(); chk_all("cap0", A, 1'b1, 1'b0, 2'd0);
    chk("m4.sel3", {24'd0, out2}, 32'h44);
    chk("m4.vld", {31'd0, vout2}, 32'd1);
    sel = 2'd1; step(); chk_all("cap1", B, 1'b1, 1'b0, 2'd0);
    sel = 2'd2; step(); chk_all("cap2", C, 1'b1, 1'b0, 2'd0);

    stall = 1'b1; data = {F, E, D};
    sel = 2'd0; vin = 1'b0; step(); chk_all("stl1", C, 1'b1, 1'b0, 2'd0);
    sel = 2'd3; vin = 1'b1; step(); chk_all("stl2", C, 1'b1, 1'b0, 2'd0);
    sel = 2'd1;             step(); chk_all("stl3", C, 1'b1, 1'b0, 2'd0);
    stall = 1'b0;           step(); chk_all("resume", E, 1'b1, 1'b0, 2'd0);

    flush = 1'b1; stall = 1'b1; sel = 2'd3;
    step(); chk_all("flush", 32'd0, 1'b0, 1'b0, 2'd0);
    flush = 1'b0; stall = 1'b0;

    step(); chk_all("oor1", 32'd0, 1'b1, 1'b1, 2'd1);
    chk("m4.noerr", {31'd0, serr2}, 32'd0);
    chk("m4.nocnt", {24'd0, cnt2}, 32'd0);
    vin = 1'b0; step(); chk_all("oor.inv", 32'd0, 1'b0, 1'b1, 2'd1);
    vin = 1'b1; stall = 1'b1;
    step(); chk_all("oor.stl", 32'd0, 1'b0, 1'b1, 2'd1);
    stall = 1'b0;
    step(); chk_all("oor2", 32'd0, 1'b1, 1'b1, 2'd2);
    step(); chk_all("oor3", 32'd0, 1'b1, 1'b1, 2'd3);
    step(); chk_all("sat4", 32'd0, 1'b1, 1'b1, 2'd3);
    step(); chk_all("sat5", 32'd0, 1'b1, 1'b1, 2'd3);
    eclr = 1'b1;
    step(); chk_all("clr", 32'd0, 1'b1, 1'b0, 2'd0);
    eclr = 1'b0; sel = 2'd0;
    step(); chk_all("post", D, 1'b1, 1'b0, 2'd0);

    sel = 2'd3; step();
    sel = 2'd1; step(); chk_all("pre.rst", E, 1'b1, 1'b1, 2'd1);
    stall = 1'b1;
    #1 reset = 1'b1;
    #2 chk_all("async", 32'd0, 1'b0, 1'b0, 2'd0);
    chk("async4", {24'd0, out2}, 32'd0);
    #1 reset = 1'b0; stall = 1'b0;
    step(); chk_all("relse", E, 1'b1, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
